// File: rtl/vfma_sequencer_if.sv
// Bundle of command, VRF read/write and multiply-add signals around the
// vector FMA element sequencer. The master view belongs to the sequencer,
// the slave view to its surroundings (command source, VRF, MAC unit).
interface vfma_sequencer_if #(
  parameter int vdw_p   = 32,
  parameter int els_p   = 16,
  parameter int nregs_p = 8
);
  localparam int elw = $clog2(els_p);
  localparam int rw  = $clog2(nregs_p);
  localparam int vlw = $clog2(els_p + 1);

  // Command handshake
  logic             v_i;
  logic             ready_o;
  logic [vlw-1:0]   vl_i;
  logic [rw-1:0]    rs0_i;
  logic [rw-1:0]    rs1_i;
  logic [rw-1:0]    rs2_i;
  logic [rw-1:0]    rd_i;

  // VRF read port
  logic             rf_r_v_o;
  logic [elw-1:0]   rf_r_el_o;
  logic [rw-1:0]    rf_r_reg0_o;
  logic [rw-1:0]    rf_r_reg1_o;
  logic [rw-1:0]    rf_r_reg2_o;
  logic [vdw_p-1:0] rf_r0_data_i;
  logic [vdw_p-1:0] rf_r1_data_i;
  logic [vdw_p-1:0] rf_r2_data_i;

  // Multiply-add unit operands and result
  logic [vdw_p-1:0] mac_r0_o;
  logic [vdw_p-1:0] mac_r1_o;
  logic [vdw_p-1:0] mac_r2_o;
  logic [vdw_p-1:0] mac_result_i;

  // VRF write port and completion
  logic             rf_w_v_o;
  logic [rw-1:0]    rf_w_reg_o;
  logic [elw-1:0]   rf_w_el_o;
  logic [vdw_p-1:0] rf_w_data_o;
  logic             done_o;

  modport master (
    input  v_i, vl_i, rs0_i, rs1_i, rs2_i, rd_i,
    input  rf_r0_data_i, rf_r1_data_i, rf_r2_data_i, mac_result_i,
    output ready_o, rf_r_v_o, rf_r_el_o, rf_r_reg0_o, rf_r_reg1_o, rf_r_reg2_o,
    output mac_r0_o, mac_r1_o, mac_r2_o,
    output rf_w_v_o, rf_w_reg_o, rf_w_el_o, rf_w_data_o, done_o
  );

  modport slave (
    output v_i, vl_i, rs0_i, rs1_i, rs2_i, rd_i,
    output rf_r0_data_i, rf_r1_data_i, rf_r2_data_i, mac_result_i,
    input  ready_o, rf_r_v_o, rf_r_el_o, rf_r_reg0_o, rf_r_reg1_o, rf_r_reg2_o,
    input  mac_r0_o, mac_r1_o, mac_r2_o,
    input  rf_w_v_o, rf_w_reg_o, rf_w_el_o, rf_w_data_o, done_o
  );
endinterface

// File: rtl/vfma_sequencer.sv
// Element sequencer for R0*R1 + R2 -> R3. Streams one element per cycle
// through read, read-response, execute and writeback with no stalls.
// The read-response bit marks the cycle in which VRF data is valid.
module vfma_sequencer #(
  parameter int vdw_p   = 32,
  parameter int els_p   = 16,
  parameter int nregs_p = 8
) (
  input logic           clk_i,
  input logic           reset_i,
  vfma_sequencer_if.master bus
);
  localparam int elw = $clog2(els_p);
  localparam int rw  = $clog2(nregs_p);
  localparam int vlw = $clog2(els_p + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e           state_q, state_n;

  logic [vlw-1:0]   cmd_vl_q;
  logic [rw-1:0]    rs0_q, rs1_q, rs2_q, rd_q;
  logic [elw-1:0]   el_cnt_q;

  logic             v_r_q, r_last_q;
  logic [elw-1:0]   r_el_q;

  logic             v_x_q, x_last_q;
  logic [elw-1:0]   x_el_q;
  logic [vdw_p-1:0] mac_r0_q, mac_r1_q, mac_r2_q;

  logic             v_w_q, w_last_q;
  logic [elw-1:0]   w_el_q;
  logic [vdw_p-1:0] w_data_q;

  logic [vlw-1:0]   vl_clamped;
  logic             accept;
  logic             issue;
  logic             last_read;

  assign vl_clamped = (bus.vl_i > vlw'(els_p)) ? vlw'(els_p) : bus.vl_i;
  assign accept     = bus.v_i && (state_q == IDLE);
  assign issue      = (state_q == ISSUE);
  assign last_read  = issue && (vlw'(el_cnt_q) == (cmd_vl_q - vlw'(1)));

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_n;
  end

  // Next state: drain leaves once nothing is left ahead of writeback
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = (vl_clamped == '0) ? DRAIN : ISSUE;
      ISSUE:   if (last_read) state_n = DRAIN;
      DRAIN:   if (!v_r_q && !v_x_q) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command capture and element counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_vl_q <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      el_cnt_q <= '0;
    end else if (accept) begin
      cmd_vl_q <= vl_clamped;
      rs0_q    <= bus.rs0_i;
      rs1_q    <= bus.rs1_i;
      rs2_q    <= bus.rs2_i;
      rd_q     <= bus.rd_i;
      el_cnt_q <= '0;
    end else if (issue) begin
      el_cnt_q <= el_cnt_q + elw'(1);
    end
  end

  // Read-response stage: tags the cycle when VRF data arrives
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r_q    <= 1'b0;
      r_el_q   <= '0;
      r_last_q <= 1'b0;
    end else begin
      v_r_q    <= issue;
      r_el_q   <= el_cnt_q;
      r_last_q <= last_read;
    end
  end

  // Execute stage: register operands for the multiply-add unit
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_x_q    <= 1'b0;
      x_el_q   <= '0;
      x_last_q <= 1'b0;
      mac_r0_q <= '0;
      mac_r1_q <= '0;
      mac_r2_q <= '0;
    end else begin
      v_x_q <= v_r_q;
      if (v_r_q) begin
        x_el_q   <= r_el_q;
        x_last_q <= r_last_q;
        mac_r0_q <= bus.rf_r0_data_i;
        mac_r1_q <= bus.rf_r1_data_i;
        mac_r2_q <= bus.rf_r2_data_i;
      end
    end
  end

  // Writeback stage: capture the multiply-add result
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_w_q    <= 1'b0;
      w_el_q   <= '0;
      w_last_q <= 1'b0;
      w_data_q <= '0;
    end else begin
      v_w_q <= v_x_q;
      if (v_x_q) begin
        w_el_q   <= x_el_q;
        w_last_q <= x_last_q;
        w_data_q <= bus.mac_result_i;
      end
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.rf_r_v_o    = issue;
  assign bus.rf_r_el_o   = el_cnt_q;
  assign bus.rf_r_reg0_o = rs0_q;
  assign bus.rf_r_reg1_o = rs1_q;
  assign bus.rf_r_reg2_o = rs2_q;
  assign bus.mac_r0_o    = mac_r0_q;
  assign bus.mac_r1_o    = mac_r1_q;
  assign bus.mac_r2_o    = mac_r2_q;
  assign bus.rf_w_v_o    = v_w_q;
  assign bus.rf_w_reg_o  = rd_q;
  assign bus.rf_w_el_o   = w_el_q;
  assign bus.rf_w_data_o = w_data_q;
  // A zero-length command completes in its single drain cycle
  assign bus.done_o      = (v_w_q && w_last_q) || ((state_q == DRAIN) && (cmd_vl_q == '0));

endmodule

// File: tb/tb_vfma_sequencer.sv
// Self-checking bench for vfma_sequencer: a VRF and MAC model surround the
// DUT; expectations come from a snapshot of the VRF and the element rules.
module tb_vfma_sequencer;
  localparam int VDW   = 32;
  localparam int ELS   = 16;
  localparam int NREGS = 8;
  localparam int VLW   = 5;
  localparam int RW    = 3;
  localparam int ELW   = 4;

  typedef struct {
    int vl;
    int rs0;
    int rs1;
    int rs2;
    int rd;
    int exp_writes;
    int exp_done;
  } vec_t;

  logic clk;
  logic reset_i;
  int   checks;
  int   failures;

  logic [VDW-1:0] vrf      [NREGS][ELS];
  logic [VDW-1:0] load_img [NREGS][ELS];
  logic           do_load;
  logic [VDW-1:0] rd0_q, rd1_q, rd2_q;

  vfma_sequencer_if #(.vdw_p(VDW), .els_p(ELS), .nregs_p(NREGS)) bus ();

  vfma_sequencer #(.vdw_p(VDW), .els_p(ELS), .nregs_p(NREGS)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // VRF model: image load, registered read port, write port
  always @(posedge clk) begin
    if (do_load) vrf <= load_img;
    else if (bus.rf_w_v_o) vrf[bus.rf_w_reg_o][bus.rf_w_el_o] <= bus.rf_w_data_o;
    if (bus.rf_r_v_o) begin
      rd0_q <= vrf[bus.rf_r_reg0_o][bus.rf_r_el_o];
      rd1_q <= vrf[bus.rf_r_reg1_o][bus.rf_r_el_o];
      rd2_q <= vrf[bus.rf_r_reg2_o][bus.rf_r_el_o];
    end
  end

  assign bus.rf_r0_data_i = rd0_q;
  assign bus.rf_r1_data_i = rd1_q;
  assign bus.rf_r2_data_i = rd2_q;
  assign bus.mac_result_i = bus.mac_r0_o * bus.mac_r1_o + bus.mac_r2_o;

  task automatic check_output(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic load_vrf();
    @(negedge clk);
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < NREGS; r++)
      for (int k = 0; k < ELS; k++)
        load_img[r][k] = $urandom;
    load_vrf();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output("ready_before_cmd", bus.ready_o, 1);
  endtask

  // Issue one command and check every read, operand, write and completion
  task automatic apply_stimulus(input int vl, input int rs0, input int rs1, input int rs2,
                                input int rd, input int exp_writes, input int exp_done);
    logic [VDW-1:0] pre [NREGS][ELS];
    logic [VDW-1:0] exp_data [ELS];
    int reads, writes, done_cnt, done_cyc, ready_cyc, k;
    pre = vrf;
    for (int e = 0; e < ELS; e++)
      exp_data[e] = (e < exp_writes) ? pre[rs0][e] * pre[rs1][e] + pre[rs2][e] : pre[rd][e];
    wait_ready();
    bus.v_i   = 1'b1;
    bus.vl_i  = VLW'(vl);
    bus.rs0_i = RW'(rs0);
    bus.rs1_i = RW'(rs1);
    bus.rs2_i = RW'(rs2);
    bus.rd_i  = RW'(rd);
    @(posedge clk);
    @(negedge clk);
    bus.v_i = 1'b0;
    reads = 0; writes = 0; done_cnt = 0; done_cyc = -1; ready_cyc = -1;
    for (int c = 1; c <= 60 && ready_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.rf_r_v_o) begin
        check_output("read_el", bus.rf_r_el_o, reads);
        check_output("read_cycle", c, reads + 1);
        check_output("read_regs", {bus.rf_r_reg0_o, bus.rf_r_reg1_o, bus.rf_r_reg2_o},
                     {RW'(rs0), RW'(rs1), RW'(rs2)});
        reads++;
      end
      k = c - 3;
      if (k >= 0 && k < exp_writes) begin
        check_output("mac_r0", bus.mac_r0_o, pre[rs0][k]);
        check_output("mac_r1", bus.mac_r1_o, pre[rs1][k]);
        check_output("mac_r2", bus.mac_r2_o, pre[rs2][k]);
      end
      if (bus.rf_w_v_o) begin
        if (writes < exp_writes) begin
          check_output("write_reg", bus.rf_w_reg_o, rd);
          check_output("write_el", bus.rf_w_el_o, writes);
          check_output("write_cycle", c, writes + 4);
          check_output("write_data", bus.rf_w_data_o, exp_data[writes]);
        end
        writes++;
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = c;
        if (exp_writes > 0)
          check_output("done_with_last_write", {bus.rf_w_v_o, bus.rf_w_el_o},
                       {1'b1, ELW'(exp_writes - 1)});
      end
      if (bus.ready_o) ready_cyc = c;
    end
    check_output("read_count", reads, exp_writes);
    check_output("write_count", writes, exp_writes);
    check_output("done_count", done_cnt, 1);
    check_output("done_cycle", done_cyc, exp_done);
    check_output("ready_cycle", ready_cyc, exp_done + 1);
    for (int e = 0; e < ELS; e++)
      check_output("vrf_dest", vrf[rd][e], exp_data[e]);
  endtask

  // Two commands with v_i held high: second accept follows first done by one
  task automatic back_to_back();
    int acc2, nw, nd;
    int w_cyc [8];
    int w_el  [8];
    int w_reg [8];
    int d_cyc [4];
    int exp_cyc [5];
    int exp_el  [5];
    int exp_reg [5];
    exp_cyc = '{4, 5, 6, 11, 12};
    exp_el  = '{0, 1, 2, 0, 1};
    exp_reg = '{0, 0, 0, 1, 1};
    wait_ready();
    bus.v_i = 1'b1; bus.vl_i = 5'd3;
    bus.rs0_i = 3'd2; bus.rs1_i = 3'd3; bus.rs2_i = 3'd4; bus.rd_i = 3'd0;
    @(posedge clk);
    @(negedge clk);
    bus.vl_i = 5'd2; bus.rd_i = 3'd1;
    acc2 = -1; nw = 0; nd = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      if (acc2 >= 0 && c == acc2 + 1) bus.v_i = 1'b0;
      if (bus.rf_w_v_o && nw < 8) begin
        w_cyc[nw] = c; w_el[nw] = int'(bus.rf_w_el_o); w_reg[nw] = int'(bus.rf_w_reg_o);
        nw++;
      end
      if (bus.done_o && nd < 4) begin
        d_cyc[nd] = c;
        nd++;
      end
      if (bus.ready_o && bus.v_i && acc2 < 0) acc2 = c;
    end
    bus.v_i = 1'b0;
    check_output("b2b_second_accept", acc2, 7);
    check_output("b2b_write_count", nw, 5);
    check_output("b2b_done_count", nd, 2);
    if (nd == 2) begin
      check_output("b2b_done0", d_cyc[0], 6);
      check_output("b2b_done1", d_cyc[1], 12);
    end
    if (nw == 5)
      for (int i = 0; i < 5; i++) begin
        check_output("b2b_write_cycle", w_cyc[i], exp_cyc[i]);
        check_output("b2b_write_el", w_el[i], exp_el[i]);
        check_output("b2b_write_reg", w_reg[i], exp_reg[i]);
      end
  endtask

  // Reset in cycle 3 of a vl=8 command aborts it; a vl=1 command follows
  task automatic reset_mid_command();
    int nw;
    fill_random();
    wait_ready();
    bus.v_i = 1'b1; bus.vl_i = 5'd8;
    bus.rs0_i = 3'd0; bus.rs1_i = 3'd1; bus.rs2_i = 3'd3; bus.rd_i = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.v_i = 1'b0;
    nw = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.rf_w_v_o) nw++;
    end
    check_output("pre_reset_reading", bus.rf_r_v_o, 1);
    reset_i = 1'b1;
    bus.v_i = 1'b1;
    #1;
    check_output("rst_ready", bus.ready_o, 1);
    check_output("rst_mac_r0", bus.mac_r0_o, 0);
    check_output("rst_w_data", bus.rf_w_data_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("rst_write_v", bus.rf_w_v_o, 0);
      check_output("rst_read_v", bus.rf_r_v_o, 0);
      check_output("rst_done", bus.done_o, 0);
    end
    bus.v_i = 1'b0;
    reset_i = 1'b0;
    #1;
    check_output("post_rst_ready", bus.ready_o, 1);
    @(negedge clk);
    check_output("post_rst_idle_read", bus.rf_r_v_o, 0);
    check_output("post_rst_ready2", bus.ready_o, 1);
    check_output("aborted_writes", nw, 0);
    apply_stimulus(1, 4, 5, 6, 2, 1, 4);
  endtask

  initial begin
    vec_t table_v [8];
    int   p1 [4];
    int   vl, n;
    checks = 0; failures = 0;
    do_load = 1'b0;
    rd0_q = '0; rd1_q = '0; rd2_q = '0;
    bus.v_i = 1'b0; bus.vl_i = '0;
    bus.rs0_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
    reset_i = 1'b0;
    #2 reset_i = 1'b1;
    bus.v_i = 1'b1;
    bus.vl_i = 5'd4;
    for (int c = 0; c < 3; c++) @(negedge clk);
    check_output("reset_ready", bus.ready_o, 1);
    check_output("reset_read_v", bus.rf_r_v_o, 0);
    check_output("reset_write_v", bus.rf_w_v_o, 0);
    check_output("reset_done", bus.done_o, 0);
    check_output("reset_mac_r1", bus.mac_r1_o, 0);
    check_output("reset_w_reg", bus.rf_w_reg_o, 0);
    bus.v_i = 1'b0;
    reset_i = 1'b0;

    // Known-value vl=4 command
    for (int r = 0; r < NREGS; r++)
      for (int k = 0; k < ELS; k++) begin
        load_img[r][k] = '0;
        if (r == 1) load_img[r][k] = VDW'(k + 1);
        if (r == 2) load_img[r][k] = 32'd2;
        if (r == 3) load_img[r][k] = 32'd10;
      end
    load_vrf();
    apply_stimulus(4, 1, 2, 3, 4, 4, 7);
    p1 = '{12, 14, 16, 18};
    for (int k = 0; k < 4; k++) check_output("known_data", vrf[4][k], p1[k]);

    // Aliased destination rd = rs0
    for (int k = 0; k < ELS; k++) begin
      load_img[5][k] = 32'd7;
      load_img[1][k] = 32'd3;
      load_img[2][k] = 32'd1;
    end
    load_vrf();
    apply_stimulus(2, 5, 1, 2, 5, 2, 5);
    check_output("alias_el0", vrf[5][0], 22);
    check_output("alias_el1", vrf[5][1], 22);
    check_output("alias_el2_untouched", vrf[5][2], 7);

    // Table of commands over random VRF contents
    table_v[0] = '{4,  1, 2, 3, 4, 4,  7};
    table_v[1] = '{0,  0, 1, 2, 3, 0,  1};
    table_v[2] = '{20, 6, 7, 0, 1, 16, 19};
    table_v[3] = '{2,  5, 1, 2, 5, 2,  5};
    table_v[4] = '{1,  3, 3, 3, 3, 1,  4};
    table_v[5] = '{16, 7, 6, 5, 0, 16, 19};
    table_v[6] = '{31, 2, 4, 6, 7, 16, 19};
    table_v[7] = '{15, 1, 0, 1, 6, 15, 18};
    fill_random();
    for (int i = 0; i < 8; i++)
      apply_stimulus(table_v[i].vl, table_v[i].rs0, table_v[i].rs1, table_v[i].rs2,
                     table_v[i].rd, table_v[i].exp_writes, table_v[i].exp_done);

    back_to_back();
    reset_mid_command();

    // Randomized commands against the element-rule model
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) fill_random();
      vl = int'($urandom_range(0, 20));
      n  = (vl > ELS) ? ELS : vl;
      apply_stimulus(vl, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     n, (vl == 0) ? 1 : n + 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
